// File: rtl/sdram_wb_arbiter_pkg.sv
// sdram_arb_pkg: state encoding, master indices and timeout fill data for the SDRAM Wishbone arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ACK} state_t;
  localparam int M_CPU = 0;
  localparam int M_DMA = 1;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/sdram_wb_arbiter_if.sv
// sdram_wb_arbiter_if: CPU and DMA Wishbone buses plus the SDRAM controller request port.
interface sdram_wb_arbiter_if #(parameter int CTRL_AW = 23);
  logic cpu_stb_i, cpu_cyc_i, cpu_we_i, cpu_ack_o;
  logic [3:0] cpu_sel_i;
  logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
  logic dma_stb_i, dma_cyc_i, dma_we_i, dma_ack_o;
  logic [3:0] dma_sel_i;
  logic [31:0] dma_adr_i, dma_dat_i, dma_dat_o;
  logic ctrl_in_valid, ctrl_rw, ctrl_busy, ctrl_out_valid;
  logic [CTRL_AW-1:0] ctrl_addr;
  logic [31:0] ctrl_data_in, ctrl_data_out;
  logic [3:0] ctrl_mask;
  modport slave (
    input cpu_stb_i, cpu_cyc_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    input dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
    input ctrl_busy, ctrl_out_valid, ctrl_data_out,
    output cpu_ack_o, cpu_dat_o, dma_ack_o, dma_dat_o,
    output ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_data_in, ctrl_mask
  );
  modport master (
    output cpu_stb_i, cpu_cyc_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    output dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
    output ctrl_busy, ctrl_out_valid, ctrl_data_out,
    input cpu_ack_o, cpu_dat_o, dma_ack_o, dma_dat_o,
    input ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_data_in, ctrl_mask
  );
endinterface

// File: rtl/sdram_wb_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way picker; last=1 means requester 1 won last, rr_en=0 gives requester 0 priority.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | ~rr_en | last);
  assign gnt[1] = req[1] & ~gnt[0];
endmodule

// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: CPU/DMA Wishbone arbiter sequencing one SDRAM controller request at a time.
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter logic [7:0] ADDR_BASE  = 8'h38,
  parameter int         CTRL_AW    = 23,
  parameter int         RD_TIMEOUT = 255,
  parameter bit         RR_EN      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  sdram_wb_arbiter_if.slave        bus,
  output logic [1:0]               grant_o,
  output logic                     timeout_o
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  state_t r_state;
  logic [1:0] r_grant;
  logic r_last, r_we, r_timeout;
  logic [3:0] r_sel;
  logic [CTRL_AW-1:0] r_adr;
  logic [31:0] r_dat, r_cpu_dat, r_dma_dat;
  logic [TW-1:0] r_timer;
  logic [1:0] w_stbcyc, w_req, w_gnt;
  logic w_accept, w_own_cyc, w_tmo, w_unused;
  logic [31:0] w_rd_data;
  assign w_stbcyc  = {bus.dma_stb_i & bus.dma_cyc_i, bus.cpu_stb_i & bus.cpu_cyc_i};
  assign w_req     = {w_stbcyc[M_DMA], w_stbcyc[M_CPU] & (bus.cpu_adr_i[31:24] == ADDR_BASE)};
  assign w_accept  = (r_state == ISSUE) & ~bus.ctrl_busy;
  assign w_own_cyc = r_grant[M_CPU] ? bus.cpu_cyc_i : bus.dma_cyc_i;
  assign w_tmo     = r_timer == TW'(RD_TIMEOUT - 1);
  assign w_rd_data = bus.ctrl_out_valid ? bus.ctrl_data_out : TIMEOUT_DATA;
  assign w_unused  = ^{bus.cpu_adr_i, bus.dma_adr_i};
  rr_arb2 u_arb (.req(w_req), .last(r_last), .rr_en(RR_EN), .gnt(w_gnt));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= 1'b1;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_timer   <= '0;
      r_timeout <= 1'b0;
      r_cpu_dat <= '0;
      r_dma_dat <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_req) begin
          r_grant <= w_gnt;
          r_we    <= w_gnt[M_CPU] ? bus.cpu_we_i : bus.dma_we_i;
          r_sel   <= w_gnt[M_CPU] ? bus.cpu_sel_i : bus.dma_sel_i;
          r_adr   <= w_gnt[M_CPU] ? bus.cpu_adr_i[CTRL_AW-1:0] : bus.dma_adr_i[CTRL_AW-1:0];
          r_dat   <= w_gnt[M_CPU] ? bus.cpu_dat_i : bus.dma_dat_i;
          r_state <= ISSUE;
        end
        ISSUE: if (w_accept) begin
          r_timer <= '0;
          r_state <= r_we ? ACK : WAIT_RD;
        end else if (!w_own_cyc) begin
          r_grant <= '0;
          r_state <= IDLE;
        end
        WAIT_RD: begin
          r_timer <= r_timer + TW'(1);
          if (bus.ctrl_out_valid || w_tmo) begin
            if (r_grant[M_CPU]) r_cpu_dat <= w_rd_data;
            else r_dma_dat <= w_rd_data;
            r_timeout <= r_timeout | ~bus.ctrl_out_valid;
            r_state   <= ACK;
          end
        end
        ACK: begin
          r_last  <= r_grant[M_DMA];
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ctrl_in_valid = r_state == ISSUE;
  assign bus.ctrl_rw       = r_we;
  assign bus.ctrl_addr     = r_adr;
  assign bus.ctrl_data_in  = r_dat;
  assign bus.ctrl_mask     = r_sel & {4{r_we}};
  assign bus.cpu_ack_o     = (r_state == ACK) & r_grant[M_CPU] & w_stbcyc[M_CPU];
  assign bus.dma_ack_o     = (r_state == ACK) & r_grant[M_DMA] & w_stbcyc[M_DMA];
  assign bus.cpu_dat_o     = r_cpu_dat;
  assign bus.dma_dat_o     = r_dma_dat;
  assign grant_o           = r_grant;
  assign timeout_o         = r_timeout;
endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Two-master Wishbone arbiter and sequencer in front of the SDRAM controller's request interface (in_valid / busy / out_valid).
- The masters are the management CPU and the DMA engine.
- It grants one transaction at a time with round-robin fairness, converts the Wishbone handshake into the controller's request/response protocol, and routes read data and acks back to the owning master.
- A read timeout guarantees that no master hangs if the controller never responds.

Parameters:
- ADDR_BASE, 8'h38: CPU request decode; cpu_adr_i[31:24] must equal this value.
- CTRL_AW, 23: controller address width; the low CTRL_AW bits of the master address are forwarded.
- RD_TIMEOUT, 255: cycles spent in WAIT_RD before the read is abandoned.
- RR_EN, 1: 1 = round-robin; 0 = fixed priority, CPU wins ties.

Ports:
- clk  in  1  system clock (wb_clk_i).
- rst  in  1  synchronous active-high reset (wb_rst_i).
- cpu_stb_i, cpu_cyc_i, cpu_we_i  in  1 each  CPU Wishbone control.
- cpu_sel_i  in  4  CPU byte select.
- cpu_adr_i, cpu_dat_i  in  32 each  CPU address / write data.
- cpu_ack_o  out  1  CPU ack.
- cpu_dat_o  out  32  CPU read data.
- dma_stb_i, dma_cyc_i, dma_we_i  in  1 each  DMA Wishbone control.
- dma_sel_i  in  4  DMA byte select.
- dma_adr_i, dma_dat_i  in  32 each  DMA address / write data.
- dma_ack_o  out  1  DMA ack.
- dma_dat_o  out  32  DMA read data.
- ctrl_in_valid  out  1  request valid to the controller.
- ctrl_rw  out  1  1 = write.
- ctrl_addr  out  CTRL_AW  request address.
- ctrl_data_in  out  32  write data.
- ctrl_mask  out  4  byte mask, equal to sel & {4{we}}.
- ctrl_busy  in  1  controller cannot accept.
- ctrl_out_valid  in  1  read data valid.
- ctrl_data_out  in  32  read data.
- grant_o  out  2  one-hot owner, [0]=CPU, [1]=DMA; 0 when idle.
- timeout_o  out  1  sticky read-timeout flag.

Behaviour:
- Reset: state IDLE; every output 0; last-winner = DMA, so the CPU wins the first tie; timer 0; holding and data registers 0.
- Request qualification:
  - cpu_req = cpu_stb_i & cpu_cyc_i & (cpu_adr_i[31:24]==ADDR_BASE).
  - dma_req = dma_stb_i & dma_cyc_i.
- IDLE:
  - If any request is present, select the winner.
  - Single request: that master wins.
  - Both requesting: the winner is the master opposite to last-winner (RR_EN=1), or the CPU (RR_EN=0).
  - Register grant_o and latch the winner's adr/dat/we/sel into holding registers, then go to ISSUE.
- ISSUE:
  - ctrl_in_valid=1; ctrl_rw, ctrl_addr, ctrl_data_in and ctrl_mask are driven only from the holding registers and stay stable while ctrl_busy=1.
  - Accept condition: ctrl_in_valid & ~ctrl_busy in the same cycle.
  - On accept, a write goes to ACK; a read goes to WAIT_RD with the timer cleared.
- WAIT_RD:
  - ctrl_in_valid=0; the timer increments every cycle.
  - ctrl_out_valid=1: capture ctrl_data_out into the owner's dat_o register, then go to ACK.
  - Timer reaches RD_TIMEOUT with no out_valid: load 32'hDEAD_BEEF into the owner's dat_o, set timeout_o (cleared only by rst), then go to ACK.
  - If out_valid and the timeout coincide, the data wins and timeout_o is not set.
- ACK:
  - Assert the owner's ack_o for exactly 1 cycle, only if that master still has stb&cyc high.
  - Update last-winner, clear grant_o, return to IDLE.
- Read-data stability: cpu_dat_o / dma_dat_o are registered and hold their value until that master's next read completes.
- Latency with busy=0: request seen in cycle 0 (IDLE), ISSUE in cycle 1, ack in cycle 2 for writes. Reads ack 1 cycle after out_valid. The next request is sampled in the cycle after ACK.
- Abort (owner drops cyc):
  - In ISSUE before accept: go to IDLE with no ack and no controller request completed.
  - After accept: the transaction completes toward the controller (WAIT_RD still drains out_valid), but the ack is suppressed.
- ctrl_out_valid outside WAIT_RD is ignored.
- A non-owner master never receives ack; its dat_o is unchanged.
- Reset mid-operation: immediate return to the reset state. ctrl_in_valid drops in the same clock edge.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT_RD, ACK);
  - the master index constants (M_CPU=0, M_DMA=1);
  - TIMEOUT_DATA=32'hDEAD_BEEF.
- Sub-module rr_arb2: a purely combinational 2-way round-robin picker. Inputs: req[1:0], last, rr_en. Output: one-hot gnt.

Test Plan:
- CPU write adr=0x3800_0010, dat=0x1234_5678, sel=4'hF, busy=0 -> ctrl_in_valid=1 for 1 cycle with ctrl_addr=0x000010, ctrl_mask=4'hF; cpu_ack_o high in cycle 2.
- CPU and DMA both request reads continuously from reset -> grants alternate CPU, DMA, CPU, DMA; each dat_o equals the model data for its own address; the other master's dat_o is unchanged.
- busy held 5 cycles during a DMA write -> ctrl_in_valid and its payload stay stable for 6 cycles; exactly one accept; one dma_ack_o.
- CPU read, controller never asserts out_valid, RD_TIMEOUT=255 -> cpu_ack_o after 255 WAIT_RD cycles with cpu_dat_o=0xDEAD_BEEF; timeout_o=1 and stays 1 until rst.
- DMA drops cyc while busy=1 in ISSUE -> return to IDLE, no ack, no accept; the pending CPU request is served next.
- rst asserted during WAIT_RD -> next cycle all outputs 0, grant_o=0; a late out_valid is ignored.
